// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch, PC register and IF/ID pipeline register
// with a one-entry skid buffer for decode stalls.
//
// Optional feature macro: FETCH_PERF_EN
//   Adds the saturating perf_fetched / perf_stall counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | post-reset cycle, no request issued
// FETCH | request at pc; returned word goes to IF/ID or to the skid entry
// FULL  | skid entry holds a word behind a stalled IF/ID; no request
`timescale 1ns/1ps

module fetch_stage #(
    parameter int          PC_W     = 8,
    parameter int          INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [3:0]         ifid_opcode
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_stall
`endif
);

    localparam logic [INSTR_W-1:0] NOP_WORD = {4'b1111, {(INSTR_W-4){1'b0}}};
    localparam logic [PC_W-1:0]    PC_INIT  = PC_W'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;
    logic               accept;
    logic               redirect_hit;

    // An empty IF/ID always loads, even while decode asserts stall.
    assign accept       = !stall || !ifid_valid;
    assign redirect_hit = redirect && (state != IDLE);

    // Request side decodes only from registered state and pc.
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign ifid_opcode = ifid_instr[INSTR_W-1 -: 4];

    // Fetch FSM, PC, skid entry and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= PC_INIT;
            skid_instr <= '0;
            skid_pc    <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_WORD;
            ifid_pc    <= '0;
        end else if (redirect_hit) begin
            // Flush wins over any same-cycle ack; the skid word is dropped.
            state      <= FETCH;
            pc         <= redirect_pc;
            skid_instr <= '0;
            skid_pc    <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_WORD;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (accept) begin
                            ifid_valid <= 1'b1;
                            ifid_instr <= imem_rdata;
                            ifid_pc    <= pc;
                        end else begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= pc;
                            state      <= FULL;
                        end
                        pc <= pc + 1'b1;
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_instr <= NOP_WORD;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_instr <= skid_instr;
                        ifid_pc    <= skid_pc;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic load_ifid;

    assign load_ifid = !redirect_hit &&
                       (((state == FETCH) && imem_ack && accept) ||
                        ((state == FULL) && !stall));

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (load_ifid && (perf_fetched != 16'hFFFF))
                perf_fetched <= perf_fetched + 16'd1;
            if (stall && ifid_valid && (perf_stall != 16'hFFFF))
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table plus hand-written
// reset and counter sequences.
`timescale 1ns/1ps

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic [3:0]  ifid_opcode;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
`endif

    logic [15:0] rd_base;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // Instruction memory: word = base | address.
    assign imem_rdata = rd_base | {8'h00, imem_addr};

    fetch_stage #(.PC_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_opcode (ifid_opcode)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    typedef struct {
        logic        ack;
        logic        stl;
        logic        redir;
        logic [7:0]  rpc;
        logic [15:0] base;
        logic        req;     // before the edge
        logic [7:0]  addr;    // before the edge
        logic        valid;   // after the edge
        logic [15:0] instr;   // after the edge
        logic        chk_pc;
        logic [7:0]  pc;      // after the edge
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req"},    {31'd0, imem_req},   32'd0);
        chk({tag, " addr"},   {24'd0, imem_addr},  32'h00);
        chk({tag, " valid"},  {31'd0, ifid_valid}, 32'd0);
        chk({tag, " instr"},  {16'd0, ifid_instr}, 32'hF000);
        chk({tag, " opcode"}, {28'd0, ifid_opcode}, 32'hF);
        chk({tag, " pc"},     {24'd0, ifid_pc},    32'h00);
`ifdef FETCH_PERF_EN
        chk({tag, " perf_fetched"}, {16'd0, perf_fetched}, 32'd0);
        chk({tag, " perf_stall"},   {16'd0, perf_stall},   32'd0);
`endif
    endtask

    initial begin
        //           ack  stl  rdr  rpc    base      req  addr   vld  instr    cpc  pc
        vecs[0]  = '{1'b1,1'b0,1'b0,8'h00,16'h1000, 1'b0,8'h00, 1'b0,16'hF000,1'b1,8'h00};
        vecs[1]  = '{1'b1,1'b0,1'b0,8'h00,16'h1000, 1'b1,8'h00, 1'b1,16'h1000,1'b1,8'h00};
        vecs[2]  = '{1'b1,1'b0,1'b0,8'h00,16'h1000, 1'b1,8'h01, 1'b1,16'h1001,1'b1,8'h01};
        vecs[3]  = '{1'b1,1'b0,1'b0,8'h00,16'h1000, 1'b1,8'h02, 1'b1,16'h1002,1'b1,8'h02};
        vecs[4]  = '{1'b1,1'b0,1'b0,8'h00,16'h1000, 1'b1,8'h03, 1'b1,16'h1003,1'b1,8'h03};
        // stall with a valid entry: word 4 goes to skid
        vecs[5]  = '{1'b1,1'b1,1'b0,8'h00,16'h1000, 1'b1,8'h04, 1'b1,16'h1003,1'b1,8'h03};
        vecs[6]  = '{1'b1,1'b1,1'b0,8'h00,16'h1000, 1'b0,8'h05, 1'b1,16'h1003,1'b1,8'h03};
        vecs[7]  = '{1'b1,1'b0,1'b0,8'h00,16'h1000, 1'b0,8'h05, 1'b1,16'h1004,1'b1,8'h04};
        vecs[8]  = '{1'b1,1'b0,1'b0,8'h00,16'h1000, 1'b1,8'h05, 1'b1,16'h1005,1'b1,8'h05};
        // three cycles without ack: bubbles, PC holds
        vecs[9]  = '{1'b0,1'b0,1'b0,8'h00,16'h1000, 1'b1,8'h06, 1'b0,16'hF000,1'b0,8'h00};
        vecs[10] = '{1'b0,1'b0,1'b0,8'h00,16'h1000, 1'b1,8'h06, 1'b0,16'hF000,1'b0,8'h00};
        vecs[11] = '{1'b0,1'b0,1'b0,8'h00,16'h1000, 1'b1,8'h06, 1'b0,16'hF000,1'b0,8'h00};
        vecs[12] = '{1'b1,1'b0,1'b0,8'h00,16'h1000, 1'b1,8'h06, 1'b1,16'h1006,1'b1,8'h06};
        // fill skid, then redirect to 0x40 while FULL
        vecs[13] = '{1'b1,1'b1,1'b0,8'h00,16'h1000, 1'b1,8'h07, 1'b1,16'h1006,1'b1,8'h06};
        vecs[14] = '{1'b1,1'b1,1'b1,8'h40,16'h1000, 1'b0,8'h08, 1'b0,16'hF000,1'b0,8'h00};
        vecs[15] = '{1'b1,1'b0,1'b0,8'h00,16'h2000, 1'b1,8'h40, 1'b1,16'h2040,1'b1,8'h40};
        // redirect with same-cycle ack: the ack is ignored
        vecs[16] = '{1'b1,1'b0,1'b1,8'hFE,16'h2000, 1'b1,8'h41, 1'b0,16'hF000,1'b0,8'h00};
        vecs[17] = '{1'b1,1'b0,1'b0,8'h00,16'h2000, 1'b1,8'hFE, 1'b1,16'h20FE,1'b1,8'hFE};
        vecs[18] = '{1'b1,1'b0,1'b0,8'h00,16'h2000, 1'b1,8'hFF, 1'b1,16'h20FF,1'b1,8'hFF};
        vecs[19] = '{1'b1,1'b0,1'b0,8'h00,16'h2000, 1'b1,8'h00, 1'b1,16'h2000,1'b1,8'h00};
        // stall with empty IF/ID is ignored
        vecs[20] = '{1'b0,1'b0,1'b0,8'h00,16'h2000, 1'b1,8'h01, 1'b0,16'hF000,1'b0,8'h00};
        vecs[21] = '{1'b1,1'b1,1'b0,8'h00,16'h2000, 1'b1,8'h01, 1'b1,16'h2001,1'b1,8'h01};
        vecs[22] = '{1'b0,1'b1,1'b0,8'h00,16'h2000, 1'b1,8'h02, 1'b1,16'h2001,1'b1,8'h01};
        vecs[23] = '{1'b0,1'b0,1'b0,8'h00,16'h2000, 1'b1,8'h02, 1'b0,16'hF000,1'b0,8'h00};

        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        rd_base     = 16'h1000;

        repeat (3) @(posedge clk);
        #1 chk_reset("reset");

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            imem_ack    = vecs[i].ack;
            stall       = vecs[i].stl;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            rd_base     = vecs[i].base;
            #1;
            chk($sformatf("v%0d req", i),  {31'd0, imem_req},  {31'd0, vecs[i].req});
            chk($sformatf("v%0d addr", i), {24'd0, imem_addr}, {24'd0, vecs[i].addr});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i),  {31'd0, ifid_valid},  {31'd0, vecs[i].valid});
            chk($sformatf("v%0d instr", i),  {16'd0, ifid_instr},  {16'd0, vecs[i].instr});
            chk($sformatf("v%0d opcode", i), {28'd0, ifid_opcode}, {28'd0, vecs[i].instr[15:12]});
            if (vecs[i].chk_pc)
                chk($sformatf("v%0d pc", i), {24'd0, ifid_pc}, {24'd0, vecs[i].pc});
            @(negedge clk);
        end

        // Reset mid-fetch with an ack in flight.
        redirect = 1'b0;
        stall    = 1'b0;
        imem_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset("midreset");

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first req", {31'd0, imem_req}, 32'd1);
        chk("first addr", {24'd0, imem_addr}, 32'h00);
        chk("first valid", {31'd0, ifid_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("run%0d valid", k), {31'd0, ifid_valid}, 32'd1);
            chk($sformatf("run%0d pc", k), {24'd0, ifid_pc}, k);
            chk($sformatf("run%0d instr", k), {16'd0, ifid_instr}, 32'h2000 + k);
        end

        @(negedge clk);
        stall    = 1'b1;
        imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d valid", k), {31'd0, ifid_valid}, 32'd1);
            chk($sformatf("hold%0d pc", k), {24'd0, ifid_pc}, 32'h04);
            chk($sformatf("hold%0d addr", k), {24'd0, imem_addr}, 32'h05);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", {16'd0, perf_fetched}, 32'd5);
        chk("perf_stall", {16'd0, perf_stall}, 32'd3);
`endif

        // Reset pulse while stalled.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("stallreset");
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(posedge clk);
        #1 chk("post reset req", {31'd0, imem_req}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
